// File: rtl/go_board_pkg.sv
// rtl/go_board_pkg.sv - shared Go Board constants: clock rate, switch count, debounce timing defaults
package go_board_pkg;

   localparam int CLK_FREQ_HZ        = 25_000_000;
   localparam int NUM_BOARD_SWITCHES = 4;

   // 10 ms settle window and 1 s hold threshold at the board clock
   localparam int DEFAULT_DEBOUNCE_CYCLES   = CLK_FREQ_HZ / 100;
   localparam int DEFAULT_LONG_PRESS_CYCLES = CLK_FREQ_HZ;

endpackage

// File: rtl/switch_debounce_events_if.sv
// rtl/switch_debounce_events_if.sv - raw switch pins in, debounced levels and event pulses out
interface switch_debounce_events_if
   import go_board_pkg::*;
#(
   parameter int NUM_SWITCHES = NUM_BOARD_SWITCHES
);

   logic [NUM_SWITCHES-1:0] i_Switch;
   logic [NUM_SWITCHES-1:0] o_Switch_State;
   logic [NUM_SWITCHES-1:0] o_Press_Pulse;
   logic [NUM_SWITCHES-1:0] o_Release_Pulse;
   logic [NUM_SWITCHES-1:0] o_Long_Press_Pulse;

   modport master (
      output i_Switch,
      input  o_Switch_State,
      input  o_Press_Pulse,
      input  o_Release_Pulse,
      input  o_Long_Press_Pulse
   );

   modport slave (
      input  i_Switch,
      output o_Switch_State,
      output o_Press_Pulse,
      output o_Release_Pulse,
      output o_Long_Press_Pulse
   );

endinterface

// File: rtl/switch_debounce_events_channel.sv
// rtl/switch_debounce_events_channel.sv - one switch: synchroniser, debounce counter, long-press timer
module switch_debounce_channel
   import go_board_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Switch,
   output logic o_Switch_State,
   output logic o_Press_Pulse,
   output logic o_Release_Pulse,
   output logic o_Long_Press_Pulse
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int LP_W = $clog2(LONG_PRESS_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

   logic            sync_meta;
   logic            sync_q;
   logic            stable;
   logic            armed;
   logic [DB_W-1:0] db_cnt;
   logic [LP_W-1:0] lp_cnt;
   logic            accept;

   // the synchronised level has disagreed long enough to become the new stable level
   assign accept = (sync_q != stable) && (db_cnt == DB_LAST);

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         sync_meta          <= 1'b0;
         sync_q             <= 1'b0;
         stable             <= 1'b0;
         armed              <= 1'b0;
         db_cnt             <= '0;
         lp_cnt             <= '0;
         o_Press_Pulse      <= 1'b0;
         o_Release_Pulse    <= 1'b0;
         o_Long_Press_Pulse <= 1'b0;
      end else begin
         sync_meta          <= i_Switch;
         sync_q             <= sync_meta;
         o_Press_Pulse      <= 1'b0;
         o_Release_Pulse    <= 1'b0;
         o_Long_Press_Pulse <= 1'b0;

         if (sync_q == stable) begin
            db_cnt <= '0;
         end else if (accept) begin
            db_cnt          <= '0;
            stable          <= sync_q;
            o_Press_Pulse   <= sync_q;
            o_Release_Pulse <= ~sync_q;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end

         // an accepted edge takes priority, so a release beats a long pulse due in the same cycle
         if (accept) begin
            lp_cnt <= '0;
            armed  <= sync_q;
         end else if (stable && armed) begin
            if (lp_cnt == LP_LAST) begin
               o_Long_Press_Pulse <= 1'b1;
               armed              <= 1'b0;
            end else begin
               lp_cnt <= lp_cnt + 1'b1;
            end
         end
      end
   end

   assign o_Switch_State = stable;

endmodule

// File: rtl/switch_debounce_events.sv
// rtl/switch_debounce_events.sv - debounced levels and press/release/long-press events for the board switches
module switch_debounce_events
   import go_board_pkg::*;
#(
   parameter int NUM_SWITCHES      = NUM_BOARD_SWITCHES,
   parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
   input  logic                     i_Clock,
   input  logic                     i_Reset,
   switch_debounce_events_if.slave  sw
);

   logic [NUM_SWITCHES-1:0] switch_state;
   logic [NUM_SWITCHES-1:0] press_pulse;
   logic [NUM_SWITCHES-1:0] release_pulse;
   logic [NUM_SWITCHES-1:0] long_press_pulse;

   for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_channel
      switch_debounce_channel #(
         .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
      ) u_channel (
         .i_Clock            (i_Clock),
         .i_Reset            (i_Reset),
         .i_Switch           (sw.i_Switch[i]),
         .o_Switch_State     (switch_state[i]),
         .o_Press_Pulse      (press_pulse[i]),
         .o_Release_Pulse    (release_pulse[i]),
         .o_Long_Press_Pulse (long_press_pulse[i])
      );
   end

   assign sw.o_Switch_State     = switch_state;
   assign sw.o_Press_Pulse      = press_pulse;
   assign sw.o_Release_Pulse    = release_pulse;
   assign sw.o_Long_Press_Pulse = long_press_pulse;

endmodule

// File: tb/tb_switch_debounce_events.sv
// tb/tb_switch_debounce_events.sv - directed bench for switch_debounce_events with short debounce timing
module tb_switch_debounce_events;

   localparam int N  = 4;
   localparam int DB = 4;
   localparam int LP = 10;

   logic i_Clock = 1'b0;
   logic i_Reset = 1'b1;
   int   total   = 0;
   int   bad     = 0;

   switch_debounce_events_if #(.NUM_SWITCHES(N)) bus ();

   switch_debounce_events #(
      .NUM_SWITCHES      (N),
      .DEBOUNCE_CYCLES   (DB),
      .LONG_PRESS_CYCLES (LP)
   ) dut (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .sw      (bus)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // compares {state, press, release, long} in one shot
   task automatic chk_out(input string tag, input logic [3:0] st, input logic [3:0] pr,
                          input logic [3:0] rl, input logic [3:0] lg);
      chk(tag, {16'h0, bus.o_Switch_State, bus.o_Press_Pulse, bus.o_Release_Pulse,
                bus.o_Long_Press_Pulse}, {16'h0, st, pr, rl, lg});
   endtask

   task automatic step();
      @(posedge i_Clock);
      @(negedge i_Clock);
   endtask

   task automatic pulse_reset();
      i_Reset = 1'b1;
      bus.i_Switch = '0;
      step();
      step();
      i_Reset = 1'b0;
   endtask

   initial begin
      bus.i_Switch = '0;

      // reset held 3 cycles, then 20 idle cycles
      for (int e = 0; e < 3; e++) begin
         @(negedge i_Clock);
         chk_out("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0);
      end
      i_Reset = 1'b0;
      for (int e = 0; e < 20; e++) begin
         step();
         chk_out("reset_idle", 4'h0, 4'h0, 4'h0, 4'h0);
      end

      // switch 0 press held: press at edge 5, long at edge 15, nothing more
      for (int e = 0; e < 36; e++) begin
         bus.i_Switch[0] = 1'b1;
         step();
         chk_out("press_hold", (e >= 5) ? 4'h1 : 4'h0, (e == 5) ? 4'h1 : 4'h0,
                 4'h0, (e == 15) ? 4'h1 : 4'h0);
      end

      // 3-cycle low glitch is rejected
      for (int e = 0; e < 10; e++) begin
         bus.i_Switch[0] = (e >= 3);
         step();
         chk_out("glitch", 4'h1, 4'h0, 4'h0, 4'h0);
      end

      // sustained low: release at edge 5
      for (int e = 0; e < 8; e++) begin
         bus.i_Switch[0] = 1'b0;
         step();
         chk_out("release", (e < 5) ? 4'h1 : 4'h0, 4'h0, (e == 5) ? 4'h1 : 4'h0, 4'h0);
      end

      // release pulse 6 cycles after press pulse: no long pulse
      for (int e = 0; e < 26; e++) begin
         bus.i_Switch[0] = (e <= 5);
         step();
         chk_out("early_release", (e >= 5 && e < 11) ? 4'h1 : 4'h0, (e == 5) ? 4'h1 : 4'h0,
                 (e == 11) ? 4'h1 : 4'h0, 4'h0);
      end

      pulse_reset();

      // switch 1 bounces in 2-cycle runs, then settles high
      for (int e = 0; e < 12; e++) begin
         bus.i_Switch[1] = ((e / 2) % 2 == 0);
         step();
         chk_out("bounce", 4'h0, 4'h0, 4'h0, 4'h0);
      end
      for (int e = 0; e < 18; e++) begin
         bus.i_Switch[1] = 1'b1;
         step();
         chk_out("settle", (e >= 5) ? 4'h2 : 4'h0, (e == 5) ? 4'h2 : 4'h0,
                 4'h0, (e == 15) ? 4'h2 : 4'h0);
      end

      pulse_reset();

      // switches 0 and 3 together
      for (int e = 0; e < 8; e++) begin
         bus.i_Switch = 4'b1001;
         step();
         chk_out("dual_press", (e >= 5) ? 4'h9 : 4'h0, (e == 5) ? 4'h9 : 4'h0, 4'h0, 4'h0);
      end

      // new press on switch 2, reset lands at edge 2 of it
      for (int e = 0; e < 3; e++) begin
         bus.i_Switch = 4'b1101;
         step();
         chk_out("pre_reset", 4'h9, 4'h0, 4'h0, 4'h0);
      end
      i_Reset = 1'b1;
      #1;
      chk_out("async_reset", 4'h0, 4'h0, 4'h0, 4'h0);
      @(negedge i_Clock);
      chk_out("in_reset", 4'h0, 4'h0, 4'h0, 4'h0);
      @(negedge i_Clock);
      i_Reset = 1'b0;
      for (int e = 0; e < 8; e++) begin
         step();
         chk_out("post_reset", (e >= 5) ? 4'hD : 4'h0, (e == 5) ? 4'hD : 4'h0, 4'h0, 4'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/switch_debounce_events.md
# switch_debounce_events

Input-side front end for the Go Board push-buttons. It synchronises and debounces up to four raw switch inputs. For each switch it produces a clean level plus single-cycle press, release and long-press event pulses. Downstream logic such as LED toggles consumes these events instead of sampling the raw pins. It sits directly between the top-level switch pins and all user logic.

## Interface
- NUM_SWITCHES, 4, number of independent switch channels (1..4)
- DEBOUNCE_CYCLES, 250000, cycles a new level must hold before acceptance (10 ms at 25 MHz); must be at least 2
- LONG_PRESS_CYCLES, 25000000, cycles after the press pulse at which a held switch raises the long-press event (1 s at 25 MHz); must be greater than DEBOUNCE_CYCLES
- i_Clock  in  1  system clock, 25 MHz
- i_Reset  in  1  asynchronous, active-high reset
- i_Switch  in  NUM_SWITCHES  raw switch pins, 1 = pressed, asynchronous to i_Clock
- o_Switch_State  out  NUM_SWITCHES  debounced level, 1 = pressed
- o_Press_Pulse  out  NUM_SWITCHES  one-cycle pulse on accepted 0->1
- o_Release_Pulse  out  NUM_SWITCHES  one-cycle pulse on accepted 1->0
- o_Long_Press_Pulse  out  NUM_SWITCHES  one-cycle pulse, at most once per press

## Operation
- Channels are fully independent; each holds the following registers:
  - 2-flop synchroniser
  - stable-level register
  - debounce counter
  - long-press counter
  - armed flag
- Reset (asynchronous assert):
  - all outputs 0
  - synchronisers, stable levels and counters 0
  - long-press armed flag clear
- Debounce (sync = synchroniser output):
  - sync == stable: debounce counter cleared to 0.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable takes sync, counter clears, matching press or release pulse registers high for the next cycle.
  - Any single cycle of agreement restarts the count, so bounce shorter than DEBOUNCE_CYCLES never changes state.
- Long press:
  - On the press pulse, long counter clears and the armed flag sets.
  - While stable == 1 and armed, long counter increments each cycle.
  - When the counter reaches LONG_PRESS_CYCLES-1, o_Long_Press_Pulse fires one cycle and armed clears.
  - Release (stable -> 0) clears the counter and armed; no long pulse follows.
- Counter widths: $clog2(DEBOUNCE_CYCLES) and $clog2(LONG_PRESS_CYCLES). Counters saturate by construction and never wrap.
- Press and release pulses for one channel are mutually exclusive. A long pulse never coincides with a press pulse.

## Timing
- Edge 0 is the first rising edge sampling the new raw level, with the level held stable thereafter.
- Sync output reflects the new level after edge 1.
- o_Switch_State and the press/release pulse update at edge DEBOUNCE_CYCLES+1. Pulse width is exactly 1 cycle.
- The long pulse rises at edge LONG_PRESS_CYCLES after the edge that raised the press pulse.
- All outputs are registered; there is no combinational path from i_Switch.
- Reset mid-count discards all progress immediately. If a switch is held while reset deasserts, its press pulse occurs at edge DEBOUNCE_CYCLES+1 counted from the first post-reset edge.
- Simultaneous events on different channels are reported in the same cycle.

## Structure
- Shared package go_board_pkg holds:
  - CLK_FREQ_HZ = 25_000_000
  - default DEBOUNCE_CYCLES and LONG_PRESS_CYCLES derived from it
  - NUM_BOARD_SWITCHES = 4
- Sub-module switch_debounce_channel implements one channel (synchroniser, debounce counter, long-press logic). The top instantiates NUM_SWITCHES copies in a generate loop.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
- Reset with i_Switch=4'b0000, held 3 cycles then released: every output 0 throughout and for 20 cycles after.
- i_Switch[0] goes 0->1 before edge 0 and holds: o_Press_Pulse[0] high only during the cycle after edge 5; o_Switch_State[0]=1 from edge 5; other channels stay 0.
- i_Switch[1] toggles every 2 cycles for 12 cycles, then settles at 1: exactly one press pulse, at edge 5 after the settle edge; no release pulse.
- With switch 0 pressed, a 3-cycle low glitch produces no release pulse. A held 0 for 4+ cycles produces one release pulse at edge 5 and o_Switch_State[0]=0.
- Long press:
  - held 30 cycles: one o_Long_Press_Pulse[0], 10 edges after the press pulse, none afterwards
  - released 6 cycles after the press pulse: no long pulse
- Switches 0 and 3 pressed in the same cycle: both press pulses in the same cycle. i_Reset asserted at edge 2 of a new press: all outputs 0 asynchronously and no pulse until the full debounce re-elapses after reset release.
